// File: rtl/barrel_normalizer.sv
// barrel_normalizer: two-stage valid/ready normalizer returning shift amount and normalized word
module barrel_normalizer #(
  parameter int DATA_LENGTH = 8,
  localparam int SW = $clog2(DATA_LENGTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_LENGTH-1:0] data_in,
  input  logic                   arith,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LENGTH-1:0] data_out,
  output logic [SW-1:0]          sa_out,
  output logic                   zero_out
);
  logic                   s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic                   s1_arith_q, s1_arith_d, zero_q, zero_d;
  logic [DATA_LENGTH-1:0] s1_data_q, s1_data_d, data_out_q, data_out_d;
  logic [SW-1:0]          sa_q, sa_d;
  logic [DATA_LENGTH-1:0] lead;
  logic [SW-1:0]          cnt;
  logic                   s1_load, s2_load;
  assign s2_load   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s2_load;
  assign s1_load   = in_valid && in_ready;
  assign out_valid = s2_valid_q;
  assign data_out  = data_out_q;
  assign sa_out    = sa_q;
  assign zero_out  = zero_q;
  // signed mode turns redundant sign bits into leading zeros, minus the sign itself; count saturates
  always_comb begin
    lead = s1_arith_q ? (s1_data_q ^ {DATA_LENGTH{s1_data_q[DATA_LENGTH-1]}}) << 1 : s1_data_q;
    cnt  = SW'(DATA_LENGTH - 1);
    for (int i = 0; i < DATA_LENGTH; i++) if (lead[i]) cnt = SW'(DATA_LENGTH - 1 - i);
  end
  // next-state for both pipeline stages; stage 2 may refill in the same cycle it drains
  always_comb begin
    s1_valid_d = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
    s1_data_d  = s1_load ? data_in : s1_data_q;
    s1_arith_d = s1_load ? arith : s1_arith_q;
    s2_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
    data_out_d = s2_load ? s1_data_q << cnt : data_out_q;
    sa_d       = s2_load ? cnt : sa_q;
    zero_d     = s2_load ? (s1_data_q == '0) || (s1_arith_q && (&s1_data_q)) : zero_q;
  end
  // pipeline registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_arith_q <= 1'b0;
      s2_valid_q <= 1'b0;
      data_out_q <= '0;
      sa_q       <= '0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_arith_q <= s1_arith_d;
      s2_valid_q <= s2_valid_d;
      data_out_q <= data_out_d;
      sa_q       <= sa_d;
      zero_q     <= zero_d;
    end
  end
endmodule

// File: tb/tb_barrel_normalizer.sv
// tb_barrel_normalizer: scoreboard bench for barrel_normalizer
module tb_barrel_normalizer;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, arith = 0;
  logic out_valid, out_ready = 0, zero_out;
  logic [7:0] data_in = 0, data_out;
  logic [2:0] sa_out;
  int n_cmp = 0, n_err = 0, cyc = 0, n_acc = 0;
  bit done = 0;
  typedef struct {logic [7:0] d; logic a; logic [7:0] ed; logic [2:0] es; logic ez; bit lat; int c;} exp_t;
  exp_t q[$];

  barrel_normalizer #(.DATA_LENGTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .arith(arith), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .sa_out(sa_out), .zero_out(zero_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [7:0] d, input logic a, output logic [7:0] x,
                                output logic [2:0] n, output logic z);
    int k = 0;
    x = d;
    while (k < 7 && !(a ? (x[7] ^ x[6]) : x[7])) begin
      x = x << 1;
      k++;
    end
    n = 3'(k);
    z = (d == 0) || (a && d == 8'hFF);
  endfunction

  task automatic send(input logic [7:0] d, input logic a, input logic [7:0] ed, input logic [2:0] es,
                      input logic ez, input bit lat, input bit push);
    exp_t e;
    in_valid = 1;
    data_in = d;
    arith = a;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e = '{d: d, a: a, ed: ed, es: es, ez: ez, lat: lat, c: cyc};
        if (push) q.push_back(e);
        n_acc++;
        @(posedge clk);
        #1 in_valid = 0;
        return;
      end
    end
    check("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic send_rand(input logic [7:0] d, input logic a);
    logic [7:0] x;
    logic [2:0] n;
    logic z;
    model(d, a, x, n, z);
    send(d, a, x, n, z, 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && q.size() != 0; t++) @(posedge clk);
    #1 check("drain_empty", q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    logic signed [7:0] sv;
    logic [7:0] r;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_output", {data_out, 5'b0, sa_out}, 0);
      else begin
        e = q.pop_front();
        check("data_out", data_out, e.ed);
        check("sa_out", sa_out, e.es);
        check("zero_out", zero_out, e.ez);
        if (e.lat) check("latency", cyc - e.c, 2);
        sv = data_out;
        r = e.a ? 8'(sv >>> sa_out) : data_out >> sa_out;
        check("reconstruct", r, e.d);
        if (!zero_out) check("normalized", e.a ? (data_out[7] ^ data_out[6]) : data_out[7], 1);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_sa_out", sa_out, 0);
    check("rst_zero_out", zero_out, 0);
    @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(8'h13, 0, 8'h98, 3, 0, 1, 1);
    send(8'h80, 0, 8'h80, 0, 0, 1, 1);
    send(8'hF3, 1, 8'h98, 3, 0, 1, 1);
    send(8'h05, 1, 8'h50, 4, 0, 1, 1);
    send(8'h40, 1, 8'h40, 0, 0, 1, 1);
    send(8'hC0, 1, 8'h80, 1, 0, 1, 1);
    send(8'h00, 0, 8'h00, 7, 1, 1, 1);
    send(8'h00, 1, 8'h00, 7, 1, 1, 1);
    send(8'hFF, 1, 8'h80, 7, 1, 1, 1);
    send(8'hFF, 0, 8'hFF, 0, 0, 1, 1);
    drain();
    // backpressure
    out_ready = 0;
    n_acc = 0;
    fork
      begin
        send(8'h01, 0, 8'h80, 7, 0, 0, 1);
        send(8'h02, 0, 8'h80, 6, 0, 0, 1);
        send(8'h04, 0, 8'h80, 5, 0, 0, 1);
        send(8'h08, 0, 8'h80, 4, 0, 0, 1);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          if (out_valid) begin
            check("stall_data_out", data_out, 8'h80);
            check("stall_sa_out", sa_out, 7);
          end
        end
        check("stall_in_ready", in_ready, 0);
        check("stall_accepted", n_acc, 2);
        check("stall_out_valid", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    // reset with both stages full
    out_ready = 0;
    send(8'h11, 0, 0, 0, 0, 0, 0);
    send(8'h22, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    out_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    // random sweep
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(2) == 0) begin
            @(posedge clk);
            #1;
          end
          send_rand(8'($urandom), 1'($urandom));
        end
        done = 1;
      end
      while (!done) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(3) != 0);
      end
    join
    out_ready = 1;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/barrel_normalizer.md
Name: barrel_normalizer

Overview:
- Inverse of the shift datapath: takes a data word and produces both the shift amount that normalizes it and the normalized word.
- Unsigned mode strips leading zeros. Signed mode strips redundant sign bits.
- Two-stage registered pipeline with valid/ready handshake on both sides. Sits ahead of the shifter or accumulator in fixed-point datapaths.
- Guarantee: right-shifting data_out by sa_out (arithmetic in signed mode, logical in unsigned mode) reproduces data_in.

Parameters:
- DATA_LENGTH, 8: data width in bits; power of two, at least 4.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  data_in and arith are valid.
- in_ready  output  1  block accepts input this cycle.
- data_in  input  DATA_LENGTH  word to normalize.
- arith  input  1  1 = signed (count redundant sign bits), 0 = unsigned (count leading zeros).
- out_valid  output  1  result fields are valid.
- out_ready  input  1  downstream accepts result.
- data_out  output  DATA_LENGTH  normalized word.
- sa_out  output  $clog2(DATA_LENGTH)  left-shift amount applied.
- zero_out  output  1  input word was zero in either mode, or all-ones in signed mode.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Both stage valid flags clear.
  - out_valid = 0, data_out = 0, sa_out = 0, zero_out = 0.
  - in_ready is combinational and equals 1 one cycle after reset.
  - Reset mid-operation discards all in-flight data; nothing is emitted afterwards.
- Transfer: input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage 1:
  - Registers data_in and arith.
  - Computes count N:
    - unsigned: N = number of leading zeros.
    - signed: N = (number of leading bits equal to the MSB) − 1.
  - N saturates at DATA_LENGTH−1.
- Stage 2:
  - Registers data_out = stage1_data << N (zero fill), sa_out = N, and zero_out.
- Pipeline control:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !s1_valid || s2_load.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to out_valid.
  - Throughput is 1 word/cycle while out_ready = 1.
- Backpressure:
  - While out_valid && !out_ready, all output fields hold stable.
  - Stage 1 holds one more word; in_ready falls once both stages are full.
- Simultaneous events: an output transfer and stage-2 load in the same cycle replace the output with no bubble. This also applies when both stages are full.
- out_valid never deasserts without an output transfer (or reset).
- Boundary cases:
  - Unsigned, data_in = 0: sa_out = DATA_LENGTH−1, data_out = 0, zero_out = 1.
  - Signed, data_in = 0: sa_out = DATA_LENGTH−1, data_out = 0, zero_out = 1.
  - Signed, data_in = all ones: sa_out = DATA_LENGTH−1, data_out = MSB only set (0x80 for 8 bits), zero_out = 1.
  - Already-normalized words (unsigned MSB = 1; signed top two bits differ): sa_out = 0, data_out = data_in.
- Purely combinational outputs: only in_ready; all result ports come from registers.

Test Plan:
- Reset then single words, out_ready = 1 (DATA_LENGTH = 8):
  - Unsigned 0x13 -> data_out 0x98, sa_out 3, zero_out 0, exactly 2 cycles after accept.
  - Unsigned 0x80 -> 0x80, sa_out 0.
- Signed cases:
  - 0xF3 -> 0x98, sa_out 3.
  - 0x05 -> 0x50, sa_out 4.
  - 0x40 -> 0x40, sa_out 0.
  - 0xC0 -> 0x80, sa_out 1.
- Degenerate cases:
  - Unsigned 0x00 -> 0x00, sa_out 7, zero_out 1.
  - Signed 0x00 -> 0x00, sa_out 7, zero_out 1.
  - Signed 0xFF -> 0x80, sa_out 7, zero_out 1.
  - Unsigned 0xFF -> 0xFF, sa_out 0, zero_out 0.
- Backpressure:
  - Stream 0x01, 0x02, 0x04, 0x08 (unsigned) with out_ready held low 5 cycles.
  - Required: in_ready drops after 2 words accepted; outputs stay at 0x80/7 while stalled.
  - After release, results emerge in order with sa_out 7, 6, 5, 4 and no loss or duplication.
- Reset mid-stream: rst_n low for 1 cycle with both stages full -> out_valid 0 next cycle; no stale result appears later.
- Random sweep, 10k words, random arith, in_valid and out_ready:
  - Right-shifting data_out by sa_out (per mode) equals data_in.
  - Result is normalized unless zero_out = 1.
  - Order is preserved.
